// File: rtl/avg_threshold_detector_if.sv
// avg_threshold_detector_if
//   Sample stream from the moving-average stage into the threshold detector.
//   Ports / signals:
//     din        signed averaged sample, DATA_WIDTH bits
//     din_valid  one-cycle strobe marking din valid
//   Modports:
//     master  producer side (the averager, or a testbench)
//     slave   consumer side (avg_threshold_detector)
interface avg_threshold_detector_if #(
    parameter int DATA_WIDTH = 16
);
    logic signed [DATA_WIDTH-1:0] din;
    logic                         din_valid;

    modport master (output din, output din_valid);
    modport slave  (input  din, input  din_valid);
endinterface

// File: rtl/avg_threshold_detector.sv
// avg_threshold_detector
//   Classifies the averaged signal as HIGH/LOW with a hysteresis band and a
//   consecutive-sample debounce, emits registered rise/fall pulses, and
//   tracks the running max/min since reset or the last clear.
//   Ports:
//     clk, rst          clock and synchronous active-high reset
//     enable            block enable; low holds every register, pulses are 0
//     smp               sample stream (din, din_valid), slave modport
//     thr_high/thr_low  signed thresholds (>= thr_high above, <= thr_low below)
//     debounce          consecutive qualifying samples to change level (0 = 1)
//     clear             one-cycle request to restart max/min tracking
//     level             debounced level, 1 = HIGH
//     level_valid       set once the first sample has been classified
//     rise_pulse        one-cycle pulse on LOW->HIGH
//     fall_pulse        one-cycle pulse on HIGH->LOW
//     max_val/min_val   signed extremes since reset/clear
//     cfg_err           set while thr_low > thr_high
module avg_threshold_detector #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    avg_threshold_detector_if.slave      smp,
    input  logic signed [DATA_WIDTH-1:0] thr_high,
    input  logic signed [DATA_WIDTH-1:0] thr_low,
    input  logic        [CNT_WIDTH-1:0]  debounce,
    input  logic                         clear,
    output logic                         level,
    output logic                         level_valid,
    output logic                         rise_pulse,
    output logic                         fall_pulse,
    output logic signed [DATA_WIDTH-1:0] max_val,
    output logic signed [DATA_WIDTH-1:0] min_val,
    output logic                         cfg_err
);

    localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    typedef enum logic [2:0] {
        ST_INIT,
        ST_LOW,
        ST_PEND_HIGH,
        ST_HIGH,
        ST_PEND_LOW
    } state_t;

    state_t                       state, state_next;
    logic        [CNT_WIDTH-1:0]  cnt, cnt_next;
    logic        [CNT_WIDTH:0]    cnt_inc;
    logic        [CNT_WIDTH-1:0]  d_eff;
    logic                         level_next, level_valid_next;
    logic                         rise_next, fall_next;
    logic signed [DATA_WIDTH-1:0] din;
    logic                         sample_cycle, cfg_bad, fsm_step;
    logic                         above, below, cnt_done;

    assign din          = smp.din;
    assign sample_cycle = enable && smp.din_valid;
    assign cfg_bad      = (thr_low > thr_high);
    // An inverted threshold pair freezes classification but not tracking.
    assign fsm_step     = sample_cycle && !cfg_bad;
    assign above        = (din >= thr_high);
    assign below        = (din <= thr_low);
    assign d_eff        = (debounce == '0) ? CNT_WIDTH'(1) : debounce;
    // One extra bit so the increment can never wrap; >= handles D shrinking
    // below an already accumulated count.
    assign cnt_inc      = {1'b0, cnt} + (CNT_WIDTH+1)'(1);
    assign cnt_done     = (cnt_inc >= {1'b0, d_eff});

    // State register plus the registered outputs of the classifier.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_INIT;
            cnt         <= '0;
            level       <= 1'b0;
            level_valid <= 1'b0;
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            level       <= level_next;
            level_valid <= level_valid_next;
            rise_pulse  <= rise_next;
            fall_pulse  <= fall_next;
        end
    end

    // Next-state logic: moves only on accepted samples.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (fsm_step) begin
            case (state)
                ST_INIT: begin
                    state_next = above ? ST_HIGH : ST_LOW;
                    cnt_next   = '0;
                end
                ST_LOW: begin
                    if (above) begin
                        if (d_eff == CNT_WIDTH'(1)) begin
                            state_next = ST_HIGH;
                            cnt_next   = '0;
                        end else begin
                            state_next = ST_PEND_HIGH;
                            cnt_next   = CNT_WIDTH'(1);
                        end
                    end
                end
                ST_PEND_HIGH: begin
                    if (!above) begin
                        state_next = ST_LOW;
                        cnt_next   = '0;
                    end else if (cnt_done) begin
                        state_next = ST_HIGH;
                        cnt_next   = '0;
                    end else begin
                        cnt_next   = cnt_inc[CNT_WIDTH-1:0];
                    end
                end
                ST_HIGH: begin
                    if (below) begin
                        if (d_eff == CNT_WIDTH'(1)) begin
                            state_next = ST_LOW;
                            cnt_next   = '0;
                        end else begin
                            state_next = ST_PEND_LOW;
                            cnt_next   = CNT_WIDTH'(1);
                        end
                    end
                end
                ST_PEND_LOW: begin
                    if (!below) begin
                        state_next = ST_HIGH;
                        cnt_next   = '0;
                    end else if (cnt_done) begin
                        state_next = ST_LOW;
                        cnt_next   = '0;
                    end else begin
                        cnt_next   = cnt_inc[CNT_WIDTH-1:0];
                    end
                end
                default: begin
                    state_next = ST_INIT;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Output logic: level follows settled states only; pulses mark a real
    // level change, never the first classification out of INIT.
    always_comb begin
        level_next       = level;
        level_valid_next = level_valid;
        rise_next        = 1'b0;
        fall_next        = 1'b0;
        if (fsm_step) begin
            level_valid_next = 1'b1;
            if (state_next == ST_HIGH) begin
                level_next = 1'b1;
            end else if (state_next == ST_LOW) begin
                level_next = 1'b0;
            end
            rise_next = (state_next == ST_HIGH) &&
                        (state == ST_LOW || state == ST_PEND_HIGH);
            fall_next = (state_next == ST_LOW) &&
                        (state == ST_HIGH || state == ST_PEND_LOW);
        end
    end

    // Configuration check, refreshed on every enabled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else if (enable) begin
            cfg_err <= cfg_bad;
        end
    end

    // Extremes tracking; a clear coinciding with a sample restarts from it.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_val <= MOST_NEG;
            min_val <= MOST_POS;
        end else if (enable) begin
            if (clear && smp.din_valid) begin
                max_val <= din;
                min_val <= din;
            end else if (clear) begin
                max_val <= MOST_NEG;
                min_val <= MOST_POS;
            end else if (smp.din_valid) begin
                if (din > max_val) max_val <= din;
                if (din < min_val) min_val <= din;
            end
        end
    end

endmodule

// File: tb/tb_avg_threshold_detector.sv
// tb_avg_threshold_detector
//   Directed testbench for avg_threshold_detector: one task per scenario,
//   each with its own hand-computed expected values.
module tb_avg_threshold_detector;

    localparam int DATA_WIDTH = 16;
    localparam int CNT_WIDTH  = 4;

    logic                         clk;
    logic                         rst;
    logic                         enable;
    logic signed [DATA_WIDTH-1:0] thr_high;
    logic signed [DATA_WIDTH-1:0] thr_low;
    logic        [CNT_WIDTH-1:0]  debounce;
    logic                         clear;
    logic                         level;
    logic                         level_valid;
    logic                         rise_pulse;
    logic                         fall_pulse;
    logic signed [DATA_WIDTH-1:0] max_val;
    logic signed [DATA_WIDTH-1:0] min_val;
    logic                         cfg_err;

    int errors = 0;
    int checks = 0;

    avg_threshold_detector_if #(.DATA_WIDTH(DATA_WIDTH)) smp ();

    avg_threshold_detector #(
        .DATA_WIDTH(DATA_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .smp        (smp.slave),
        .thr_high   (thr_high),
        .thr_low    (thr_low),
        .debounce   (debounce),
        .clear      (clear),
        .level      (level),
        .level_valid(level_valid),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .max_val    (max_val),
        .min_val    (min_val),
        .cfg_err    (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one sample for one cycle; outputs are settled 1 time unit after
    // the edge that consumes it.
    task automatic send_sample(input logic signed [DATA_WIDTH-1:0] v);
        smp.din       = v;
        smp.din_valid = 1'b1;
        @(posedge clk);
        #1;
        smp.din_valid = 1'b0;
        clear         = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_cycle();
        checks++; if (level !== 1'b0) begin errors++; $display("[TB] FAIL reset_level got=%0d exp=0", level); end
        checks++; if (level_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_level_valid got=%0d exp=0", level_valid); end
        checks++; if (rise_pulse !== 1'b0 || fall_pulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses got=%b%b exp=00", rise_pulse, fall_pulse); end
        checks++; if (max_val !== -16'sd32768) begin errors++; $display("[TB] FAIL reset_max got=%0d exp=-32768", max_val); end
        checks++; if (min_val !== 16'sd32767) begin errors++; $display("[TB] FAIL reset_min got=%0d exp=32767", min_val); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_cfg_err got=%0d exp=0", cfg_err); end
        rst = 1'b0;
    endtask

    task automatic test_init_high();
        thr_high = 16'sd50;
        thr_low  = -16'sd50;
        debounce = 4'd0;
        send_sample(16'sd100);
        checks++; if (level !== 1'b1) begin errors++; $display("[TB] FAIL init_level got=%0d exp=1", level); end
        checks++; if (level_valid !== 1'b1) begin errors++; $display("[TB] FAIL init_level_valid got=%0d exp=1", level_valid); end
        checks++; if (rise_pulse !== 1'b0) begin errors++; $display("[TB] FAIL init_no_rise got=%0d exp=0", rise_pulse); end
        checks++; if (max_val !== 16'sd100 || min_val !== 16'sd100) begin errors++; $display("[TB] FAIL init_maxmin got=%0d/%0d exp=100/100", max_val, min_val); end
        // Drop to LOW with debounce 0 (treated as 1): immediate fall.
        send_sample(-16'sd60);
        checks++; if (fall_pulse !== 1'b1 || level !== 1'b0) begin errors++; $display("[TB] FAIL init_to_low got fall=%0d level=%0d exp fall=1 level=0", fall_pulse, level); end
    endtask

    task automatic test_debounce_rise();
        debounce = 4'd3;
        send_sample(16'sd60);
        checks++; if (rise_pulse !== 1'b0 || level !== 1'b0) begin errors++; $display("[TB] FAIL deb_s1 got rise=%0d level=%0d exp 0/0", rise_pulse, level); end
        send_sample(16'sd60);
        checks++; if (rise_pulse !== 1'b0 || level !== 1'b0) begin errors++; $display("[TB] FAIL deb_s2 got rise=%0d level=%0d exp 0/0", rise_pulse, level); end
        send_sample(16'sd60);
        checks++; if (rise_pulse !== 1'b1 || level !== 1'b1) begin errors++; $display("[TB] FAIL deb_s3 got rise=%0d level=%0d exp 1/1", rise_pulse, level); end
        idle_cycle();
        checks++; if (rise_pulse !== 1'b0 || level !== 1'b1) begin errors++; $display("[TB] FAIL deb_one_cycle got rise=%0d level=%0d exp 0/1", rise_pulse, level); end
        // Back to LOW, then an interrupted run of above-threshold samples.
        debounce = 4'd1;
        send_sample(-16'sd60);
        checks++; if (fall_pulse !== 1'b1 || level !== 1'b0) begin errors++; $display("[TB] FAIL deb_back_low got fall=%0d level=%0d exp 1/0", fall_pulse, level); end
        debounce = 4'd3;
        send_sample(16'sd60);
        send_sample(16'sd60);
        send_sample(16'sd10);
        checks++; if (rise_pulse !== 1'b0 || level !== 1'b0) begin errors++; $display("[TB] FAIL deb_abort got rise=%0d level=%0d exp 0/0", rise_pulse, level); end
        send_sample(16'sd60);
        checks++; if (rise_pulse !== 1'b0 || level !== 1'b0) begin errors++; $display("[TB] FAIL deb_restart got rise=%0d level=%0d exp 0/0", rise_pulse, level); end
        // Lowering D mid-debounce: cnt=1 already, next qualifying sample completes.
        debounce = 4'd1;
        send_sample(16'sd60);
        checks++; if (rise_pulse !== 1'b1 || level !== 1'b1) begin errors++; $display("[TB] FAIL deb_new_d got rise=%0d level=%0d exp 1/1", rise_pulse, level); end
    endtask

    task automatic test_band_fall();
        debounce = 4'd3;
        send_sample(16'sd0);
        send_sample(-16'sd10);
        send_sample(-16'sd49);
        checks++; if (fall_pulse !== 1'b0 || level !== 1'b1) begin errors++; $display("[TB] FAIL band_hold got fall=%0d level=%0d exp 0/1", fall_pulse, level); end
        debounce = 4'd1;
        send_sample(-16'sd50);
        checks++; if (fall_pulse !== 1'b1 || level !== 1'b0) begin errors++; $display("[TB] FAIL band_fall got fall=%0d level=%0d exp 1/0", fall_pulse, level); end
        idle_cycle();
        checks++; if (fall_pulse !== 1'b0) begin errors++; $display("[TB] FAIL band_fall_one_cycle got=%0d exp=0", fall_pulse); end
    endtask

    task automatic test_cfg_err();
        thr_low  = 16'sd100;
        thr_high = -16'sd100;
        send_sample(16'sd200);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("[TB] FAIL cfg_err_set got=%0d exp=1", cfg_err); end
        checks++; if (rise_pulse !== 1'b0 || level !== 1'b0) begin errors++; $display("[TB] FAIL cfg_hold_hi got rise=%0d level=%0d exp 0/0", rise_pulse, level); end
        send_sample(-16'sd200);
        checks++; if (fall_pulse !== 1'b0 || rise_pulse !== 1'b0 || level !== 1'b0) begin errors++; $display("[TB] FAIL cfg_hold_lo got rise=%0d fall=%0d level=%0d exp 0/0/0", rise_pulse, fall_pulse, level); end
        checks++; if (max_val !== 16'sd200 || min_val !== -16'sd200) begin errors++; $display("[TB] FAIL cfg_maxmin got=%0d/%0d exp=200/-200", max_val, min_val); end
        thr_high = 16'sd50;
        thr_low  = -16'sd50;
        idle_cycle();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL cfg_err_clear got=%0d exp=0", cfg_err); end
    endtask

    task automatic test_clear();
        send_sample(-16'sd32768);
        send_sample(16'sd32767);
        checks++; if (max_val !== 16'sd32767 || min_val !== -16'sd32768) begin errors++; $display("[TB] FAIL clr_extremes got=%0d/%0d exp=32767/-32768", max_val, min_val); end
        checks++; if (rise_pulse !== 1'b1 || level !== 1'b1) begin errors++; $display("[TB] FAIL clr_rise got rise=%0d level=%0d exp 1/1", rise_pulse, level); end
        clear = 1'b1;
        send_sample(16'sd5);
        checks++; if (max_val !== 16'sd5 || min_val !== 16'sd5) begin errors++; $display("[TB] FAIL clr_with_sample got=%0d/%0d exp=5/5", max_val, min_val); end
        clear = 1'b1;
        idle_cycle();
        clear = 1'b0;
        checks++; if (max_val !== -16'sd32768 || min_val !== 16'sd32767) begin errors++; $display("[TB] FAIL clr_alone got=%0d/%0d exp=-32768/32767", max_val, min_val); end
        checks++; if (level !== 1'b1) begin errors++; $display("[TB] FAIL clr_level got=%0d exp=1", level); end
    endtask

    task automatic test_enable();
        enable = 1'b0;
        clear  = 1'b1;
        send_sample(-16'sd1000);
        checks++; if (level !== 1'b1 || fall_pulse !== 1'b0) begin errors++; $display("[TB] FAIL en_hold_fsm got level=%0d fall=%0d exp 1/0", level, fall_pulse); end
        checks++; if (max_val !== -16'sd32768 || min_val !== 16'sd32767) begin errors++; $display("[TB] FAIL en_hold_maxmin got=%0d/%0d exp=-32768/32767", max_val, min_val); end
        enable = 1'b1;
        idle_cycle();
        checks++; if (level !== 1'b1 || max_val !== -16'sd32768) begin errors++; $display("[TB] FAIL en_not_queued got level=%0d max=%0d exp 1/-32768", level, max_val); end
    endtask

    task automatic test_reset_mid_debounce();
        debounce = 4'd1;
        send_sample(-16'sd60);
        debounce = 4'd3;
        send_sample(16'sd60);
        send_sample(16'sd60);
        // Reset wins even with a qualifying sample present.
        rst           = 1'b1;
        smp.din       = 16'sd60;
        smp.din_valid = 1'b1;
        idle_cycle();
        smp.din_valid = 1'b0;
        rst           = 1'b0;
        checks++; if (level !== 1'b0 || level_valid !== 1'b0 || rise_pulse !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_outputs got level=%0d valid=%0d rise=%0d exp 0/0/0", level, level_valid, rise_pulse); end
        checks++; if (max_val !== -16'sd32768 || min_val !== 16'sd32767) begin errors++; $display("[TB] FAIL rstmid_maxmin got=%0d/%0d exp=-32768/32767", max_val, min_val); end
        // From INIT the next sample classifies directly, without a pulse.
        send_sample(16'sd60);
        checks++; if (level !== 1'b1 || level_valid !== 1'b1 || rise_pulse !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_init got level=%0d valid=%0d rise=%0d exp 1/1/0", level, level_valid, rise_pulse); end
    endtask

    // Scenario sequence; each task leaves the DUT in the state the next expects.
    initial begin
        rst           = 1'b1;
        enable        = 1'b1;
        smp.din       = '0;
        smp.din_valid = 1'b0;
        thr_high      = 16'sd50;
        thr_low       = -16'sd50;
        debounce      = 4'd0;
        clear         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] starting directed tests");
        test_reset();
        test_init_high();
        test_debounce_rise();
        test_band_fall();
        test_cfg_err();
        test_clear();
        test_enable();
        test_reset_mid_debounce();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
